tap_cmd_issuer: RTL and testbench

Initiator side of the 32-bit command/trigger register bus used by the tap-step and similar command-parsing blocks. Accepts a host get/set request, forms the command word, generates the trigger pulse and holds the command stable while the responder parses it. Then samples the responder's `outputValue` after a fixed wait and returns it with a valid strobe. Sits between the host link (UART/MCU decoder) and one or more command responders.

---
 rtl/tap_cmd_issuer.sv | 189 ++++++++++++++++++
 tb/tb_tap_cmd_issuer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tap_cmd_issuer.sv
// Initiator for the 32-bit command/trigger register bus: forms a get/set command word, pulses the trigger,
// waits for the responder and returns its readback. Define TAP_CMD_ISSUER_VERIFY_EN to add set-then-readback verify.
module tap_cmd_issuer #(
  parameter int unsigned TRIG_CYCLES = 2,
  parameter int unsigned RESP_WAIT   = 4,
  parameter logic [31:0] VERIFY_MASK = 32'h0000000F
) (
  input  logic        clk,
  input  logic        rest,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqIsSet,
  input  logic [3:0]  reqAddr,
  input  logic [23:0] reqData,
  output logic [31:0] cmdOut,
  output logic        cmdTrigger,
  input  logic [31:0] cmdReadback,
  output logic        rspValid,
  output logic [31:0] rspData,
  output logic        rspErr
);

  localparam logic [31:0] ERR_PATTERN = 32'hA55AAA55;
  localparam logic [3:0]  OP_SET      = 4'd7;
  localparam logic [3:0]  OP_GET      = 4'd6;

`ifdef TAP_CMD_ISSUER_VERIFY_EN
  typedef enum logic [3:0] {
    IDLE, LOAD, TRIG, WAIT, CAPTURE, VLOAD, VTRIG, VWAIT, VCHECK
  } state_t;
`else
  typedef enum logic [3:0] {
    IDLE, LOAD, TRIG, WAIT, CAPTURE
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] cmd_q, cmd_d;
  logic        trig_q, trig_d;
  logic        ready_q, ready_d;
  logic        rspv_q, rspv_d;
  logic [31:0] rspd_q, rspd_d;
  logic        rspe_q, rspe_d;
  logic        set_q, set_d;
`ifdef TAP_CMD_ISSUER_VERIFY_EN
  logic [23:0] vdata_q, vdata_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    trig_d  = trig_q;
    ready_d = ready_q;
    rspv_d  = 1'b0;
    rspd_d  = rspd_q;
    rspe_d  = rspe_q;
    set_d   = set_q;
`ifdef TAP_CMD_ISSUER_VERIFY_EN
    vdata_d = vdata_q;
`endif
    case (state_q)
      IDLE: begin
        if (reqValid) begin
          cmd_d   = {(reqIsSet ? OP_SET : OP_GET), reqAddr, reqData};
          set_d   = reqIsSet;
`ifdef TAP_CMD_ISSUER_VERIFY_EN
          vdata_d = reqData;
`endif
          ready_d = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        trig_d  = 1'b1;
        cnt_d   = 8'(TRIG_CYCLES - 1);
        state_d = TRIG;
      end
      TRIG: begin
        if (cnt_q == 8'd0) begin
          trig_d  = 1'b0;
          cnt_d   = 8'(RESP_WAIT - 1);
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      WAIT: begin
        if (cnt_q == 8'd0) begin
`ifdef TAP_CMD_ISSUER_VERIFY_EN
          if (set_q) begin
            // Re-address the same register as a get so its outputValue reflects the write.
            cmd_d   = {OP_GET, cmd_q[27:0]};
            state_d = VLOAD;
          end else begin
            state_d = CAPTURE;
          end
`else
          state_d = CAPTURE;
`endif
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      CAPTURE: begin
        rspv_d  = 1'b1;
        rspd_d  = set_q ? 32'd0 : cmdReadback;
        rspe_d  = !set_q && (cmdReadback == ERR_PATTERN);
        ready_d = 1'b1;
        state_d = IDLE;
      end
`ifdef TAP_CMD_ISSUER_VERIFY_EN
      VLOAD: begin
        trig_d  = 1'b1;
        cnt_d   = 8'(TRIG_CYCLES - 1);
        state_d = VTRIG;
      end
      VTRIG: begin
        if (cnt_q == 8'd0) begin
          trig_d  = 1'b0;
          cnt_d   = 8'(RESP_WAIT - 1);
          state_d = VWAIT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      VWAIT: begin
        if (cnt_q == 8'd0) begin
          state_d = VCHECK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      VCHECK: begin
        rspv_d  = 1'b1;
        rspd_d  = cmdReadback;
        rspe_d  = ((cmdReadback & VERIFY_MASK) != ({8'd0, vdata_q} & VERIFY_MASK)) ||
                  (cmdReadback == ERR_PATTERN);
        ready_d = 1'b1;
        state_d = IDLE;
      end
`endif
      default: begin
        trig_d  = 1'b0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      cmd_q   <= 32'd0;
      trig_q  <= 1'b0;
      ready_q <= 1'b1;
      rspv_q  <= 1'b0;
      rspd_q  <= 32'd0;
      rspe_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      trig_q  <= trig_d;
      ready_q <= ready_d;
      rspv_q  <= rspv_d;
      rspd_q  <= rspd_d;
      rspe_q  <= rspe_d;
    end
  end

  // Request attributes are only consumed after an accept, so they need no reset.
  always_ff @(posedge clk) begin
    set_q   <= set_d;
`ifdef TAP_CMD_ISSUER_VERIFY_EN
    vdata_q <= vdata_d;
`endif
  end

  assign reqReady   = ready_q;
  assign cmdOut     = cmd_q;
  assign cmdTrigger = trig_q;
  assign rspValid   = rspv_q;
  assign rspData    = rspd_q;
  assign rspErr     = rspe_q;

endmodule

// File: tb/tb_tap_cmd_issuer.sv
// Directed bench for tap_cmd_issuer: reset, gets, sets (with or without verify), back-to-back and mid-transaction reset.
module tb_tap_cmd_issuer;

  logic        clk = 1'b0;
  logic        rest;
  logic        reqValid;
  logic        reqReady;
  logic        reqIsSet;
  logic [3:0]  reqAddr;
  logic [23:0] reqData;
  logic [31:0] cmdOut;
  logic        cmdTrigger;
  logic [31:0] cmdReadback;
  logic        rspValid;
  logic [31:0] rspData;
  logic        rspErr;

  int total = 0;
  int bad   = 0;

  tap_cmd_issuer dut (
    .clk        (clk),
    .rest       (rest),
    .reqValid   (reqValid),
    .reqReady   (reqReady),
    .reqIsSet   (reqIsSet),
    .reqAddr    (reqAddr),
    .reqData    (reqData),
    .cmdOut     (cmdOut),
    .cmdTrigger (cmdTrigger),
    .cmdReadback(cmdReadback),
    .rspValid   (rspValid),
    .rspData    (rspData),
    .rspErr     (rspErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request; k counts cycles after the accept edge (LOAD is k=1).
  task automatic txn(input string tag, input logic is_set, input logic [3:0] addr,
                     input logic [23:0] data, input logic [31:0] rb,
                     input logic [31:0] exp_cmd, input logic [31:0] exp_cmd2,
                     input int exp_lat, input int exp_rises,
                     input logic [31:0] exp_data, input logic exp_err);
    int          wait_n, k, rises, high_n, first_rise, lat, cmd_chg;
    logic        prev_trig, got_err;
    logic [31:0] prev_cmd, got_data;
    @(negedge clk);
    reqValid = 1'b1; reqIsSet = is_set; reqAddr = addr; reqData = data; cmdReadback = rb;
    wait_n = 0;
    while (!reqReady && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    chk({tag, "_ready_before_accept"}, 32'(reqReady), 32'd1);
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    k = 1;
    chk({tag, "_ready_busy"}, 32'(reqReady), 32'd0);
    chk({tag, "_cmd_load"}, cmdOut, exp_cmd);
    chk({tag, "_trig_load"}, 32'(cmdTrigger), 32'd0);
    prev_trig = 1'b0; prev_cmd = cmdOut;
    rises = 0; high_n = 0; first_rise = 0; lat = 0; cmd_chg = 0;
    got_data = 32'd0; got_err = 1'b0;
    while (lat == 0 && k <= 40) begin
      if (cmdTrigger && !prev_trig) begin
        rises++;
        if (first_rise == 0) first_rise = k;
      end
      if (cmdTrigger) high_n++;
      if (cmdOut !== prev_cmd) cmd_chg++;
      if (rspValid) begin
        lat = k; got_data = rspData; got_err = rspErr;
      end
      prev_trig = cmdTrigger; prev_cmd = cmdOut;
      if (lat == 0) begin
        @(negedge clk);
        k++;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_first_rise"}, 32'(first_rise), 32'd2);
    chk({tag, "_rises"}, 32'(rises), 32'(exp_rises));
    chk({tag, "_trig_high"}, 32'(high_n), 32'(exp_rises * 2));
    chk({tag, "_cmd_changes"}, 32'(cmd_chg), 32'(exp_rises - 1));
    chk({tag, "_cmd_final"}, cmdOut, exp_cmd2);
    chk({tag, "_rsp_data"}, got_data, exp_data);
    chk({tag, "_rsp_err"}, 32'(got_err), 32'(exp_err));
    @(negedge clk);
    chk({tag, "_rsp_strobe_end"}, 32'(rspValid), 32'd0);
    chk({tag, "_ready_after"}, 32'(reqReady), 32'd1);
  endtask

  logic [3:0]  b2b_addr [3] = '{4'h2, 4'h3, 4'h4};
  logic [23:0] b2b_data [3] = '{24'h000010, 24'h00ABCD, 24'h800001};
  logic [31:0] b2b_cmd  [3] = '{32'h62000010, 32'h6300ABCD, 32'h64800001};

  initial begin
    int   trig_n, rsp_n, idx, accepts, bad_chg, low_run, min_gap, rises;
    int   acc_cyc [3];
    logic acc_pend, prev_trig, seen_high;
    logic [31:0] prev_cmd;

    rest = 1'b0; reqValid = 1'b0; reqIsSet = 1'b0; reqAddr = 4'h0; reqData = 24'h0;
    cmdReadback = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd", cmdOut, 32'h0);
    chk("rst_trig", 32'(cmdTrigger), 32'd0);
    chk("rst_ready", 32'(reqReady), 32'd1);
    chk("rst_rspvalid", 32'(rspValid), 32'd0);
    chk("rst_rspdata", rspData, 32'h0);
    chk("rst_rsperr", 32'(rspErr), 32'd0);
    rest = 1'b1;

    trig_n = 0; rsp_n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmdTrigger) trig_n++;
      if (rspValid) rsp_n++;
    end
    chk("idle_trig_cycles", 32'(trig_n), 32'd0);
    chk("idle_rsp_count", 32'(rsp_n), 32'd0);
    chk("idle_ready", 32'(reqReady), 32'd1);

    txn("get_a1", 1'b0, 4'h1, 24'h000000, 32'h0000001A,
        32'h61000000, 32'h61000000, 9, 1, 32'h0000001A, 1'b0);
    txn("get_a5_errpat", 1'b0, 4'h5, 24'h0000AB, 32'hA55AAA55,
        32'h650000AB, 32'h650000AB, 9, 1, 32'hA55AAA55, 1'b1);
`ifdef TAP_CMD_ISSUER_VERIFY_EN
    txn("set_verify_ok", 1'b1, 4'h1, 24'h000007, 32'h00000007,
        32'h71000007, 32'h61000007, 16, 2, 32'h00000007, 1'b0);
    txn("set_verify_bad", 1'b1, 4'h1, 24'h000007, 32'h00000003,
        32'h71000007, 32'h61000007, 16, 2, 32'h00000003, 1'b1);
    txn("set_verify_hibits", 1'b1, 4'hF, 24'hFFFFF5, 32'hFFFFFF05,
        32'h7FFFFFF5, 32'h6FFFFFF5, 16, 2, 32'hFFFFFF05, 1'b0);
`else
    txn("set_a1", 1'b1, 4'h1, 24'h000007, 32'h00000003,
        32'h71000007, 32'h71000007, 9, 1, 32'h00000000, 1'b0);
    txn("set_errpat_ignored", 1'b1, 4'h1, 24'h000007, 32'hA55AAA55,
        32'h71000007, 32'h71000007, 9, 1, 32'h00000000, 1'b0);
    txn("set_full_width", 1'b1, 4'hF, 24'hFFFFFF, 32'h12345678,
        32'h7FFFFFFF, 32'h7FFFFFFF, 9, 1, 32'h00000000, 1'b0);
`endif

    // Back-to-back gets with reqValid held high throughout.
    @(negedge clk);
    reqValid = 1'b1; reqIsSet = 1'b0; idx = 0;
    reqAddr = b2b_addr[0]; reqData = b2b_data[0]; cmdReadback = 32'h00000C0D;
    acc_pend = reqValid && reqReady;
    accepts = 0; bad_chg = 0; rsp_n = 0; rises = 0; low_run = 0; min_gap = 1000;
    seen_high = 1'b0; prev_trig = cmdTrigger; prev_cmd = cmdOut;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (acc_pend) begin
        if (accepts < 3) acc_cyc[accepts] = c;
        accepts++;
        if (idx < 3) chk("b2b_cmd_on_accept", cmdOut, b2b_cmd[idx]);
        idx++;
        if (idx < 3) begin
          reqAddr = b2b_addr[idx]; reqData = b2b_data[idx];
        end else begin
          reqValid = 1'b0;
        end
      end else if (cmdOut !== prev_cmd) begin
        bad_chg++;
      end
      if (cmdTrigger && !prev_trig) begin
        rises++;
        if (seen_high && low_run < min_gap) min_gap = low_run;
      end
      if (cmdTrigger) begin
        seen_high = 1'b1; low_run = 0;
      end else begin
        low_run++;
      end
      if (rspValid) begin
        rsp_n++;
        chk("b2b_rsp_data", rspData, 32'h00000C0D);
      end
      acc_pend = reqValid && reqReady;
      prev_trig = cmdTrigger; prev_cmd = cmdOut;
    end
    chk("b2b_accepts", 32'(accepts), 32'd3);
    chk("b2b_spacing_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd9);
    chk("b2b_spacing_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd9);
    chk("b2b_cmd_stable", 32'(bad_chg), 32'd0);
    chk("b2b_rsp_count", 32'(rsp_n), 32'd3);
    chk("b2b_rises", 32'(rises), 32'd3);
    chk("b2b_min_low_gap_ok", 32'(min_gap >= 5), 32'd1);

    // Reset asserted while the trigger is high.
    @(negedge clk);
    reqValid = 1'b1; reqIsSet = 1'b0; reqAddr = 4'h9; reqData = 24'h000042;
    cmdReadback = 32'h0BADF00D;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    @(negedge clk);
    chk("midrst_trig_before", 32'(cmdTrigger), 32'd1);
    rest = 1'b0;
    #1;
    chk("midrst_trig_drop", 32'(cmdTrigger), 32'd0);
    chk("midrst_cmd", cmdOut, 32'h0);
    chk("midrst_ready", 32'(reqReady), 32'd1);
    chk("midrst_rspvalid", 32'(rspValid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rest = 1'b1;
    trig_n = 0; rsp_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmdTrigger) trig_n++;
      if (rspValid) rsp_n++;
    end
    chk("midrst_no_rsp", 32'(rsp_n), 32'd0);
    chk("midrst_no_trig", 32'(trig_n), 32'd0);
    txn("after_reset_get", 1'b0, 4'h9, 24'h000042, 32'h0BADF00D,
        32'h69000042, 32'h69000042, 9, 1, 32'h0BADF00D, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
